// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: accepts one RISC-V word at a time, decodes ADD/SUB/ADDI
// and drives the DataPath control inputs through DECODE, EXEC and WB.

`ifndef ADD
`define ADD 7'd1
`endif
`ifndef SUB
`define SUB 7'd2
`endif

module datapath_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             stall,
  output logic [6:0]       dp_op,
  output logic [4:0]       dp_addr_a,
  output logic [4:0]       dp_addr_b,
  output logic [4:0]       dp_addr_d,
  output logic [31:0]      dp_immed,
  output logic             dp_y_sel,
  output logic             dp_write,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] TRAP   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] instr_q;

  logic        dec_legal;
  logic [6:0]  dec_op;
  logic [31:0] dec_immed;
  logic        dec_y_sel;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = `ADD;
    dec_immed = 32'd0;
    dec_y_sel = 1'b0;
    if (opcode == 7'b0110011 && funct3 == 3'b000) begin
      if (funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_op    = `ADD;
      end else if (funct7 == 7'b0100000) begin
        dec_legal = 1'b1;
        dec_op    = `SUB;
      end
    end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
      dec_legal = 1'b1;
      dec_op    = `ADD;
      dec_y_sel = 1'b1;
      dec_immed = {{20{instr_q[31]}}, instr_q[31:20]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  state_next = dec_legal ? EXEC : TRAP;
      EXEC:    if (!stall) state_next = WB;
      WB:      state_next = IDLE;
      TRAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            instr_q <= 32'd0;
    else if (state == IDLE && instr_valid) instr_q <= instr;
  end

  // Operand registers load on the DECODE->EXEC step and otherwise hold, so
  // they stay stable through WB and keep their last values in IDLE and TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_op     <= 7'd0;
      dp_addr_a <= 5'd0;
      dp_addr_b <= 5'd0;
      dp_addr_d <= 5'd0;
      dp_immed  <= 32'd0;
      dp_y_sel  <= 1'b0;
    end else if (state == DECODE && dec_legal) begin
      dp_op     <= dec_op;
      dp_addr_a <= instr_q[19:15];
      dp_addr_b <= instr_q[24:20];
      dp_addr_d <= instr_q[11:7];
      dp_immed  <= dec_immed;
      dp_y_sel  <= dec_y_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           retired <= '0;
    else if (state == WB) retired <= retired + CNT_W'(1);
  end

  // Status outputs decode the state directly so an async reset clears them at once.
  assign instr_ready = (state == IDLE) && rst_n;
  assign busy        = (state != IDLE);
  assign done        = (state == WB);
  assign illegal     = (state == TRAP);
  assign dp_write    = (state == WB) && (dp_addr_d != 5'd0);

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid, input, 1: an instruction is offered on instr.
REQ-005 SHALL have port instr_ready, output, 1: the sequencer accepts instr this cycle.
REQ-006 SHALL have port instr, input, 32: RISC-V-format word (opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]).
REQ-007 SHALL have port stall, input, 1: freezes the sequencer in EXEC.
REQ-008 SHALL have ports dp_op (output, 7), dp_addr_a (output, 5), dp_addr_b (output, 5), dp_addr_d (output, 5), dp_immed (output, 32), dp_y_sel (output, 1) and dp_write (output, 1), driving the DataPath op, addr_a, addr_b, addr_d, immed, y_sel and write inputs.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when an instruction retires.
REQ-010 SHALL have port illegal, output, 1: one-cycle pulse when an instruction is rejected.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port retired, output, CNT_W: count of retired instructions.

Function
REQ-013 SHALL implement the FSM states IDLE, DECODE, EXEC, WB and TRAP.
REQ-014 SHALL assert instr_ready only in IDLE; a handshake (instr_valid && instr_ready) SHALL latch instr into an internal register and move the FSM to DECODE.
REQ-015 SHALL ignore instr and instr_valid in every state other than IDLE.
REQ-016 In DECODE, the sequencer SHALL decode the latched word and move to EXEC if the instruction is legal, otherwise to TRAP.
REQ-017 Legal instructions:
- opcode 0110011, funct3 000, funct7 0000000 -> `ADD, dp_y_sel=0.
- opcode 0110011, funct3 000, funct7 0100000 -> `SUB, dp_y_sel=0.
- opcode 0010011, funct3 000 -> `ADD, dp_y_sel=1, dp_immed = sign-extended instr[31:20].
- Op codes SHALL come from CONSTANTS.vh.
REQ-018 All other encodings SHALL be illegal.
REQ-019 Operand outputs (dp_op, dp_addr_a=rs1, dp_addr_b=rs2, dp_addr_d=rd, dp_immed, dp_y_sel) SHALL be registered and held stable from EXEC entry through WB exit.
REQ-020 For R-type instructions, dp_immed SHALL be 0.
REQ-021 Operand outputs SHALL hold their last values in IDLE and TRAP.
REQ-022 In EXEC, the FSM SHALL stay in EXEC while stall=1 and move to WB on the first cycle with stall=0.
REQ-023 dp_write SHALL be 0 in every state except WB.
REQ-024 In WB, dp_write SHALL be 1 for exactly one cycle, or 0 if rd=0 (r0 is never written).
REQ-025 In WB, done SHALL be 1 and retired SHALL increment by 1, including when rd=0.
REQ-026 WB SHALL always return to IDLE.
REQ-027 retired SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-028 In TRAP, illegal SHALL be 1 for one cycle, with no write and no increment of retired; TRAP SHALL always return to IDLE.
REQ-029 Latency with no stall: handshake at edge N; DECODE in cycle N+1, EXEC in N+2, WB (done, dp_write) in N+3; instr_ready high again in N+4.
REQ-030 Each stall cycle SHALL add exactly one cycle of latency.
REQ-031 Throughput SHALL be at most one instruction per 4 cycles; there is no pipelining and no buffering.
REQ-032 stall asserted outside EXEC SHALL have no effect.
REQ-033 done and illegal SHALL never be high in the same cycle.

Reset
REQ-034 When rst_n=0, the sequencer SHALL asynchronously enter IDLE.
REQ-035 During reset, outputs SHALL be: instr_ready=0, busy=0, done=0, illegal=0, dp_write=0, dp_op=0, all dp_addr_*=0, dp_immed=0, dp_y_sel=0, retired=0.
REQ-036 instr_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-037 Reset in any state, including mid-WB, SHALL abort the in-flight instruction: no done pulse and no retired increment afterwards, and dp_write SHALL drop to 0 immediately.

Verification
REQ-038 ADDI x5, x0, 5 (0x00500293) -> dp_op=`ADD, dp_addr_a=0, dp_addr_d=5, dp_immed=0x00000005, dp_y_sel=1; dp_write=1 and done=1 in cycle N+3; retired=1.
REQ-039 ADDI x1, x0, -1 (0xFFF00093) -> dp_immed=0xFFFFFFFF.
REQ-040 SUB x3, x1, x2 (0x402081B3) with stall high for 3 EXEC cycles -> dp_op=`SUB, dp_addr_a=1, dp_addr_b=2, dp_addr_d=3, dp_y_sel=0; done in cycle N+6.
REQ-041 ADD x0, x1, x2 (0x00208033) -> done=1, dp_write=0 throughout, retired increments.
REQ-042 Word 0x00001033 (funct3=001) -> illegal=1 in cycle N+2, dp_write never 1, retired unchanged, instr_ready=1 in N+3.
REQ-043 rst_n pulsed low during WB -> dp_write=0 immediately, retired=0, instr_ready=1 in the first cycle after release; with CNT_W=4 and 16 retirements -> retired reads 0.
